// File: rtl/volley_pkg.sv
// Shared types for the volleyball set/match scorer: FSM state and undo history entry.
package volley_pkg;

    // Widest point counter a history entry can hold; the scorer zero-extends into it.
    localparam int SCORE_MAX_W = 16;

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        SET_DONE   = 2'd1,
        MATCH_DONE = 2'd2
    } scorer_state_t;

    typedef struct packed {
        logic [SCORE_MAX_W-1:0] a;
        logic [SCORE_MAX_W-1:0] b;
        logic                   serve;
    } hist_entry_t;

endpackage

// File: rtl/score_history.sv
// LIFO of point-state snapshots; a push onto a full stack overwrites the oldest entry.
module score_history
    import volley_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        push,
    input  logic        pop,
    input  hist_entry_t push_entry,
    output hist_entry_t top_entry,
    output logic        empty
);

    localparam int D     = (DEPTH < 1) ? 1 : DEPTH;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
    localparam int CNT_W = $clog2(D + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(D - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(D);

    hist_entry_t      mem_q [D];
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] top_idx;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == LAST) ? '0 : i + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_dec(input logic [IDX_W-1:0] i);
        return (i == '0) ? LAST : i - 1'b1;
    endfunction

    // head_q points at the next write slot, so the newest entry sits just below it.
    assign top_idx   = wrap_dec(head_q);
    assign top_entry = mem_q[top_idx];
    assign empty     = (count_q == '0);

    // Pointer/occupancy update; clear wins over push, push over pop.
    always_comb begin
        head_d  = head_q;
        count_d = count_q;
        if (clr) begin
            head_d  = '0;
            count_d = '0;
        end else if (push) begin
            head_d = wrap_inc(head_q);
            if (count_q != FULL) begin
                count_d = count_q + 1'b1;
            end
        end else if (pop && !empty) begin
            head_d  = top_idx;
            count_d = count_q - 1'b1;
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    // Snapshot storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_q[head_q] <= push_entry;
        end
    end

endmodule

// File: rtl/volley_set_scorer.sv
// Two-team volleyball scorer: rally points, set/match wins, serve tracking and undo.
module volley_set_scorer
    import volley_pkg::*;
#(
    parameter int W           = 6,
    parameter int SET_PTS     = 25,
    parameter int TIE_PTS     = 15,
    parameter int MARGIN      = 2,
    parameter int SETS_TO_WIN = 3,
    parameter int UNDO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             point_a,
    input  logic                             point_b,
    input  logic                             undo,
    input  logic                             next_set,
    input  logic                             new_match,
    output logic [W-1:0]                     score_a,
    output logic [W-1:0]                     score_b,
    output logic [$clog2(SETS_TO_WIN+1)-1:0] sets_a,
    output logic [$clog2(SETS_TO_WIN+1)-1:0] sets_b,
    output logic                             serve,
    output logic                             deciding,
    output logic                             set_won,
    output logic                             winner,
    output logic                             match_done,
    output logic                             undo_empty
);

    localparam int SW = $clog2(SETS_TO_WIN + 1);
    localparam logic [W-1:0]  SCORE_MAX = '1;
    localparam logic [W:0]    SET_T     = (W+1)'(SET_PTS);
    localparam logic [W:0]    TIE_T     = (W+1)'(TIE_PTS);
    localparam logic [W:0]    MARGIN_X  = (W+1)'(MARGIN);
    localparam logic [SW-1:0] SETS_PEN  = SW'(SETS_TO_WIN - 1);

    scorer_state_t state_q, state_d;
    logic [W-1:0]  score_a_q, score_a_d, score_b_q, score_b_d;
    logic [SW-1:0] sets_a_q, sets_a_d, sets_b_q, sets_b_d;
    logic          serve_q, serve_d;
    logic          winner_q, winner_d;
    logic          set_won_q, set_won_d;

    logic          clear_all;
    logic          hist_push, hist_pop, hist_clr, hist_empty;
    hist_entry_t   hist_in, hist_top;
    logic [W:0]    target, ext_a, ext_b;
    logic          win_a, win_b;

    // new_match is a full match reset, identical in effect to rst.
    assign clear_all = rst | new_match;

    assign deciding = (sets_a_q == SETS_PEN) && (sets_b_q == SETS_PEN);
    assign target   = deciding ? TIE_T : SET_T;

    assign hist_in = '{a: SCORE_MAX_W'(score_a_q), b: SCORE_MAX_W'(score_b_q), serve: serve_q};

    score_history #(
        .DEPTH      (UNDO_DEPTH)
    ) u_history (
        .clk        (clk),
        .rst        (clear_all),
        .clr        (hist_clr),
        .push       (hist_push),
        .pop        (hist_pop),
        .push_entry (hist_in),
        .top_entry  (hist_top),
        .empty      (hist_empty)
    );

    if (W < SCORE_MAX_W) begin : g_hist_hi
        logic unused_hist_hi;
        assign unused_hist_hi = ^{hist_top.a[SCORE_MAX_W-1:W], hist_top.b[SCORE_MAX_W-1:W]};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (clear_all) begin
            state_q <= PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a set win leaves PLAY in the same cycle as the deciding point.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PLAY: begin
                if (win_a) begin
                    state_d = (sets_a_q == SETS_PEN) ? MATCH_DONE : SET_DONE;
                end else if (win_b) begin
                    state_d = (sets_b_q == SETS_PEN) ? MATCH_DONE : SET_DONE;
                end
            end
            SET_DONE: begin
                if (next_set) begin
                    state_d = PLAY;
                end
            end
            MATCH_DONE: state_d = MATCH_DONE;
            default:    state_d = PLAY;
        endcase
    end

    // Point, undo and next-set handling for the scores, serve and history.
    always_comb begin
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        serve_d   = serve_q;
        hist_push = 1'b0;
        hist_pop  = 1'b0;
        hist_clr  = 1'b0;
        case (state_q)
            PLAY: begin
                if (undo) begin
                    if (!hist_empty) begin
                        hist_pop  = 1'b1;
                        score_a_d = hist_top.a[W-1:0];
                        score_b_d = hist_top.b[W-1:0];
                        serve_d   = hist_top.serve;
                    end
                end else if (point_a && !point_b) begin
                    // A saturated score makes the point a no-op, so nothing is recorded.
                    if (score_a_q != SCORE_MAX) begin
                        hist_push = 1'b1;
                        score_a_d = score_a_q + 1'b1;
                        serve_d   = 1'b0;
                    end
                end else if (point_b && !point_a) begin
                    if (score_b_q != SCORE_MAX) begin
                        hist_push = 1'b1;
                        score_b_d = score_b_q + 1'b1;
                        serve_d   = 1'b1;
                    end
                end
            end
            SET_DONE: begin
                if (next_set) begin
                    score_a_d = '0;
                    score_b_d = '0;
                    hist_clr  = 1'b1;
                    serve_d   = ~winner_q;
                end
            end
            default: ;
        endcase
    end

    // Set-win test on post-update scores, widened by one bit so +MARGIN cannot wrap.
    assign ext_a = {1'b0, score_a_d};
    assign ext_b = {1'b0, score_b_d};
    assign win_a = (state_q == PLAY) && (ext_a >= target) && (ext_a >= ext_b + MARGIN_X);
    assign win_b = (state_q == PLAY) && !win_a && (ext_b >= target) && (ext_b >= ext_a + MARGIN_X);

    // Set counts, winner and the one-cycle set_won pulse.
    always_comb begin
        sets_a_d  = sets_a_q;
        sets_b_d  = sets_b_q;
        winner_d  = winner_q;
        set_won_d = 1'b0;
        if (win_a) begin
            sets_a_d  = sets_a_q + 1'b1;
            winner_d  = 1'b0;
            set_won_d = 1'b1;
        end else if (win_b) begin
            sets_b_d  = sets_b_q + 1'b1;
            winner_d  = 1'b1;
            set_won_d = 1'b1;
        end
    end

    // Registered scoreboard outputs.
    always_ff @(posedge clk) begin
        if (clear_all) begin
            score_a_q <= '0;
            score_b_q <= '0;
            sets_a_q  <= '0;
            sets_b_q  <= '0;
            serve_q   <= 1'b0;
            winner_q  <= 1'b0;
            set_won_q <= 1'b0;
        end else begin
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
            sets_a_q  <= sets_a_d;
            sets_b_q  <= sets_b_d;
            serve_q   <= serve_d;
            winner_q  <= winner_d;
            set_won_q <= set_won_d;
        end
    end

    assign score_a    = score_a_q;
    assign score_b    = score_b_q;
    assign sets_a     = sets_a_q;
    assign sets_b     = sets_b_q;
    assign serve      = serve_q;
    assign winner     = winner_q;
    assign set_won    = set_won_q;
    assign match_done = (state_q == MATCH_DONE);
    assign undo_empty = hist_empty;

endmodule

// File: tb/tb_volley_set_scorer.sv
// Bench for volley_set_scorer: rule-level reference model, per-cycle compare, directed and random stimulus.
module tb_volley_set_scorer;

    localparam int W           = 6;
    localparam int SET_PTS     = 25;
    localparam int TIE_PTS     = 15;
    localparam int MARGIN      = 2;
    localparam int SETS_TO_WIN = 3;
    localparam int UNDO_DEPTH  = 4;
    localparam int SW          = $clog2(SETS_TO_WIN + 1);
    localparam int MAXS        = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          point_a = 1'b0, point_b = 1'b0, undo = 1'b0, next_set = 1'b0, new_match = 1'b0;
    logic [W-1:0]  score_a, score_b;
    logic [SW-1:0] sets_a, sets_b;
    logic          serve, deciding, set_won, winner, match_done, undo_empty;

    int checks = 0;
    int errors = 0;

    volley_set_scorer #(
        .W(W), .SET_PTS(SET_PTS), .TIE_PTS(TIE_PTS), .MARGIN(MARGIN),
        .SETS_TO_WIN(SETS_TO_WIN), .UNDO_DEPTH(UNDO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .point_a(point_a), .point_b(point_b), .undo(undo),
        .next_set(next_set), .new_match(new_match),
        .score_a(score_a), .score_b(score_b), .sets_a(sets_a), .sets_b(sets_b),
        .serve(serve), .deciding(deciding), .set_won(set_won), .winner(winner),
        .match_done(match_done), .undo_empty(undo_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integers and a snapshot queue.
    typedef struct { int a; int b; int s; } snap_t;
    snap_t hist[$];
    int  m_a, m_b, m_serve, m_sa, m_sb, m_winner;
    bit  m_won, m_set_over, m_match_over, m_ok = 0;

    function automatic bit wins(input int me, input int other, input int tgt);
        return (me >= tgt) && (me >= other + MARGIN);
    endfunction

    always @(posedge clk) begin
        int    tgt;
        snap_t e;
        m_won = 0;
        if (rst || new_match) begin
            m_a = 0; m_b = 0; m_serve = 0; m_sa = 0; m_sb = 0; m_winner = 0;
            m_set_over = 0; m_match_over = 0;
            hist.delete();
            m_ok = 1;
        end else if (m_match_over) begin
        end else if (m_set_over) begin
            if (next_set) begin
                m_a = 0; m_b = 0; m_serve = 1 - m_winner;
                hist.delete();
                m_set_over = 0;
            end
        end else begin
            if (undo) begin
                if (hist.size() > 0) begin
                    e = hist.pop_back();
                    m_a = e.a; m_b = e.b; m_serve = e.s;
                end
            end else if (point_a != point_b) begin
                if (point_a && m_a < MAXS) begin
                    hist.push_back('{m_a, m_b, m_serve});
                    m_a++; m_serve = 0;
                end else if (point_b && m_b < MAXS) begin
                    hist.push_back('{m_a, m_b, m_serve});
                    m_b++; m_serve = 1;
                end
                if (hist.size() > UNDO_DEPTH) void'(hist.pop_front());
            end
            tgt = (m_sa == SETS_TO_WIN - 1 && m_sb == SETS_TO_WIN - 1) ? TIE_PTS : SET_PTS;
            if (wins(m_a, m_b, tgt)) begin
                m_sa++; m_winner = 0; m_won = 1;
                if (m_sa == SETS_TO_WIN) m_match_over = 1; else m_set_over = 1;
            end else if (wins(m_b, m_a, tgt)) begin
                m_sb++; m_winner = 1; m_won = 1;
                if (m_sb == SETS_TO_WIN) m_match_over = 1; else m_set_over = 1;
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("score_a", int'(score_a), m_a);
            chk("score_b", int'(score_b), m_b);
            chk("sets_a", int'(sets_a), m_sa);
            chk("sets_b", int'(sets_b), m_sb);
            chk("serve", int'(serve), m_serve);
            chk("deciding", int'(deciding), int'(m_sa == SETS_TO_WIN - 1 && m_sb == SETS_TO_WIN - 1));
            chk("set_won", int'(set_won), int'(m_won));
            chk("winner", int'(winner), m_winner);
            chk("match_done", int'(match_done), int'(m_match_over));
            chk("undo_empty", int'(undo_empty), int'(hist.size() == 0));
        end
    end

    task automatic step(input bit pa, input bit pb, input bit u, input bit ns, input bit nm);
        point_a = pa; point_b = pb; undo = u; next_set = ns; new_match = nm;
        @(posedge clk);
        #1;
    endtask

    // Awards points to one team until the set is won (bounded), then acknowledges it.
    task automatic win_for(input bit team);
        int n = 0;
        do begin
            step(!team, team, 0, 0, 0);
            n++;
        end while (!set_won && n < 200);
        chk("win_bound", int'(set_won), 1);
        step(0, 0, 0, 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        chk("rst_score_a", int'(score_a), 0);
        chk("rst_undo_empty", int'(undo_empty), 1);
        chk("rst_match_done", int'(match_done), 0);

        // A takes 25 straight points.
        for (int i = 0; i < 25; i++) step(1, 0, 0, 0, 0);
        chk("t1_score_a", int'(score_a), 25);
        chk("t1_set_won", int'(set_won), 1);
        chk("t1_sets_a", int'(sets_a), 1);
        chk("t1_winner", int'(winner), 0);
        step(1, 0, 0, 0, 0);
        chk("t1_frozen", int'(score_a), 25);
        chk("t1_pulse_end", int'(set_won), 0);
        step(0, 0, 0, 1, 0);
        chk("t1_serve_loser", int'(serve), 1);

        // Deuce: 24-24 then A, B, A, A.
        for (int i = 0; i < 24; i++) begin
            step(1, 0, 0, 0, 0);
            step(0, 1, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0);
        chk("t2_25_24", int'(sets_a), 1);
        step(0, 1, 0, 0, 0);
        chk("t2_25_25", int'(sets_a), 1);
        step(1, 0, 0, 0, 0);
        chk("t2_26_25", int'(sets_a), 1);
        step(1, 0, 0, 0, 0);
        chk("t2_27_score", int'(score_a), 27);
        chk("t2_27_win", int'(sets_a), 2);
        step(0, 0, 0, 1, 0);

        // Three points, five undos.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("t3_serve_b", int'(serve), 1);
        step(0, 0, 1, 0, 0);
        chk("t3_undo1_b", int'(score_b), 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("t3_undo3_a", int'(score_a), 0);
        chk("t3_undo3_empty", int'(undo_empty), 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("t3_extra_a", int'(score_a), 0);
        chk("t3_serve_restored", int'(serve), 1);

        // Six points overflow a depth-4 history.
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        chk("t4_restore2", int'(score_a), 2);
        chk("t4_empty", int'(undo_empty), 1);
        step(0, 0, 1, 0, 0);
        chk("t4_extra", int'(score_a), 2);

        // Simultaneous points, undo beats a point.
        step(1, 1, 0, 0, 0);
        chk("t5_both_a", int'(score_a), 2);
        chk("t5_both_b", int'(score_b), 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("t5_undo_pri_a", int'(score_a), 2);
        chk("t5_undo_pri_b", int'(score_b), 0);

        // B wins two sets to reach 2-2.
        win_for(1);
        win_for(1);
        chk("t6_deciding", int'(deciding), 1);

        // Deciding set: 15-14 is not a win, 17-15 ends the match.
        for (int i = 0; i < 14; i++) begin
            step(1, 0, 0, 0, 0);
            step(0, 1, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0);
        chk("t7_15_14", int'(match_done), 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("t7_match_done", int'(match_done), 1);
        chk("t7_sets_a", int'(sets_a), 3);
        chk("t7_winner", int'(winner), 0);
        step(0, 0, 0, 1, 0);
        chk("t7_next_ignored", int'(match_done), 1);
        step(1, 0, 0, 0, 0);
        chk("t7_point_ignored", int'(score_a), 17);

        // New match, back to 2-2, deciding set won 15-13.
        step(0, 0, 0, 0, 1);
        chk("t8_nm_sets", int'(sets_a), 0);
        chk("t8_nm_md", int'(match_done), 0);
        win_for(0);
        win_for(1);
        win_for(0);
        win_for(1);
        for (int i = 0; i < 13; i++) begin
            step(0, 1, 0, 0, 0);
            step(1, 0, 0, 0, 0);
        end
        step(1, 0, 0, 0, 0);
        chk("t8_14_13", int'(match_done), 0);
        step(1, 0, 0, 0, 0);
        chk("t8_15_13", int'(match_done), 1);
        chk("t8_sets_a", int'(sets_a), 3);

        // Mid-set new_match and rst.
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        chk("t9_nm_score_a", int'(score_a), 0);
        chk("t9_nm_score_b", int'(score_b), 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        rst = 1'b1;
        step(1, 0, 0, 0, 0);
        rst = 1'b0;
        chk("t9_rst_score_b", int'(score_b), 0);
        chk("t9_rst_serve", int'(serve), 0);
        chk("t9_rst_empty", int'(undo_empty), 1);

        // Randomised play.
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 999) == 0);
            step($urandom_range(0, 99) < 48, $urandom_range(0, 99) < 48,
                 $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 399) == 0);
        end
        rst = 1'b0;
        step(0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
